compare_seq_ctrl: RTL and testbench



---
 rtl/compare_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_compare_seq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/compare_seq_ctrl.sv
// Bit-serial magnitude/equality compare controller: walks two WIDTH-bit operands
// MSB first through a 1-bit compare cell and reports eq/gt/lt with a start/done handshake.
module compare_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1,
    parameter int CW         = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [CW-1:0]    bit_cnt
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic             r_decided;
    logic             r_gtBit;
    logic             r_ltBit;
    logic             r_eqOut;
    logic             r_gtOut;
    logic             r_ltOut;
    logic [CW-1:0]    r_cnt;

    logic             w_aBit;
    logic             w_mismatch;
    logic             w_exit;
    logic             w_decidedNext;
    logic             w_gtNext;
    logic             w_ltNext;

    // The 1-bit compare cell; once a verdict exists, later bits cannot change it.
    assign w_aBit        = r_a[r_idx];
    assign w_mismatch    = w_aBit ^ r_b[r_idx];
    assign w_exit        = (r_idx == '0) || (EARLY_EXIT && w_mismatch);
    assign w_decidedNext = r_decided | w_mismatch;
    assign w_gtNext      = r_decided ? r_gtBit : (w_mismatch & w_aBit);
    assign w_ltNext      = r_decided ? r_ltBit : (w_mismatch & ~w_aBit);

    assign eq      = r_eqOut;
    assign gt      = r_gtOut;
    assign lt      = r_ltOut;
    assign bit_cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_exit) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Result registers are loaded on the RUN->DONE edge so they are valid with done and then held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_decided <= 1'b0;
            r_gtBit   <= 1'b0;
            r_ltBit   <= 1'b0;
            r_eqOut   <= 1'b0;
            r_gtOut   <= 1'b0;
            r_ltOut   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_idx     <= IW'(WIDTH - 1);
                        r_decided <= 1'b0;
                        r_gtBit   <= 1'b0;
                        r_ltBit   <= 1'b0;
                        r_eqOut   <= 1'b0;
                        r_gtOut   <= 1'b0;
                        r_ltOut   <= 1'b0;
                        r_cnt     <= '0;
                    end
                end
                RUN: begin
                    r_cnt     <= r_cnt + CW'(1);
                    r_decided <= w_decidedNext;
                    r_gtBit   <= w_gtNext;
                    r_ltBit   <= w_ltNext;
                    if (w_exit) begin
                        r_eqOut <= ~w_decidedNext;
                        r_gtOut <= w_gtNext;
                        r_ltOut <= w_ltNext;
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compare_seq_ctrl.sv
// Scoreboard bench for compare_seq_ctrl: one full-scan and one early-exit instance,
// expected results queued at start and checked by a monitor whenever done pulses.
module tb_compare_seq_ctrl;

    typedef struct {
        int   dut;
        logic eq;
        logic gt;
        logic lt;
        int   cnt;
        int   doneCycle;
        int   busyLen;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] aIn;
    logic [7:0] bIn;
    logic       startV [2];
    logic       busyV  [2];
    logic       doneV  [2];
    logic       eqV    [2];
    logic       gtV    [2];
    logic       ltV    [2];
    logic [3:0] cntV   [2];

    exp_t sbQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycleCnt   = 0;
    int   busyCnt [2];

    // Instance 0 always scans all bits, instance 1 stops at the first mismatch.
    compare_seq_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dutFull (
        .clk(clk), .rst(rst), .start(startV[0]), .a(aIn), .b(bIn),
        .busy(busyV[0]), .done(doneV[0]), .eq(eqV[0]), .gt(gtV[0]), .lt(ltV[0]),
        .bit_cnt(cntV[0])
    );

    compare_seq_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dutEarly (
        .clk(clk), .rst(rst), .start(startV[1]), .a(aIn), .b(bIn),
        .busy(busyV[1]), .done(doneV[1]), .eq(eqV[1]), .gt(gtV[1]), .lt(ltV[1]),
        .bit_cnt(cntV[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    // Caller sits at a negedge; returns at the negedge of the first RUN cycle.
    task automatic applyStimulus(input int d, input logic [7:0] av, input logic [7:0] bv,
                                 input logic expEq, input logic expGt, input logic expLt,
                                 input int expCnt, input int expLat);
        exp_t e;
        startV[d] = 1'b1;
        aIn = av;
        bIn = bv;
        @(posedge clk);
        @(negedge clk);
        startV[d] = 1'b0;
        aIn = ~av;
        bIn = ~bv;
        checkOutput("clearedOnRunEntry", {eqV[d], gtV[d], ltV[d]}, 0);
        checkOutput("cntZeroOnRunEntry", cntV[d], 0);
        e.dut       = d;
        e.eq        = expEq;
        e.gt        = expGt;
        e.lt        = expLt;
        e.cnt       = expCnt;
        e.doneCycle = cycleCnt + expLat;
        e.busyLen   = expLat + 1;
        sbQ.push_back(e);
    endtask

    task automatic waitIdle(input int d);
        int n = 0;
        while ((busyV[d] || sbQ.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idleWithinBudget", (n < 60) ? 1 : 0, 1);
    endtask

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (busyV[d]) busyCnt[d]++;
            else          busyCnt[d] = 0;
            if (doneV[d]) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedDone", 1, 0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("doneInstance", d, e.dut);
                    checkOutput("eq", eqV[d], e.eq);
                    checkOutput("gt", gtV[d], e.gt);
                    checkOutput("lt", ltV[d], e.lt);
                    checkOutput("bitCnt", cntV[d], e.cnt);
                    checkOutput("doneCycle", cycleCnt, e.doneCycle);
                    checkOutput("busyLength", busyCnt[d], e.busyLen);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        busyCnt[0] = 0;
        busyCnt[1] = 0;
        rst = 1'b1;
        startV[0] = 1'b0;
        startV[1] = 1'b0;
        aIn = '0;
        bIn = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("resetBusy", busyV[d], 0);
            checkOutput("resetDone", doneV[d], 0);
            checkOutput("resetFlags", {eqV[d], gtV[d], ltV[d]}, 0);
            checkOutput("resetCnt", cntV[d], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Early-exit instance: directed vectors
        applyStimulus(1, 8'hA5, 8'hA5, 1, 0, 0, 8, 8); waitIdle(1);
        applyStimulus(1, 8'h80, 8'h7F, 0, 1, 0, 1, 1); waitIdle(1);
        repeat (2) @(negedge clk);
        checkOutput("heldGt", gtV[1], 1);
        checkOutput("heldCnt", cntV[1], 1);
        applyStimulus(1, 8'h12, 8'h13, 0, 0, 1, 8, 8); waitIdle(1);
        applyStimulus(1, 8'h0F, 8'hF0, 0, 0, 1, 1, 1); waitIdle(1);
        applyStimulus(1, 8'hFF, 8'hFE, 0, 1, 0, 8, 8); waitIdle(1);
        applyStimulus(1, 8'h01, 8'h80, 0, 0, 1, 1, 1); waitIdle(1);

        // Full-scan instance
        applyStimulus(0, 8'h40, 8'h3F, 0, 1, 0, 8, 8); waitIdle(0);
        applyStimulus(0, 8'h0F, 8'hF0, 0, 0, 1, 8, 8); waitIdle(0);
        applyStimulus(0, 8'h00, 8'h00, 1, 0, 0, 8, 8); waitIdle(0);

        // Starts while busy (RUN and DONE) are ignored; the cycle after DONE is accepted
        applyStimulus(1, 8'h55, 8'h55, 1, 0, 0, 8, 8);
        repeat (3) @(negedge clk);
        startV[1] = 1'b1; aIn = 8'h00; bIn = 8'hFF;
        @(negedge clk);
        startV[1] = 1'b0;
        repeat (4) @(negedge clk);
        startV[1] = 1'b1; aIn = 8'hFF; bIn = 8'h00;
        @(negedge clk);
        startV[1] = 1'b0;
        applyStimulus(1, 8'h3C, 8'h3D, 0, 0, 1, 8, 8); waitIdle(1);

        // Reset in the third RUN cycle aborts without a done pulse
        startV[0] = 1'b1; aIn = 8'hFF; bIn = 8'h00;
        @(negedge clk);
        startV[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortBusy", busyV[0], 0);
        checkOutput("abortFlags", {eqV[0], gtV[0], ltV[0]}, 0);
        checkOutput("abortCnt", cntV[0], 0);
        repeat (12) @(negedge clk);
        checkOutput("abortStaysIdle", busyV[0], 0);
        applyStimulus(0, 8'hFF, 8'h00, 0, 1, 0, 8, 8); waitIdle(0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboardDrained", sbQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
